frame_check: RTL and testbench

Receive-side pattern checker for the GTP link bring-up path. Sits on the `rx_clk` domain after the transceiver and consumes the 16-bit `rx_data`/`rxcharisk` stream. Hunts for the K28.5 comma frame, locks after a run of correct frames, then counts word errors and frames so link integrity is visible in simulation and in hardware.

---
 rtl/frame_check.sv | 144 ++++++++++++++
 tb/tb_frame_check.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_check.sv
// Receive-side K28.5 frame checker: hunts for the comma, locks after LOCK_COUNT
// clean frames, then counts mismatching words and checked frames while locked.
module frame_check #(
  parameter int unsigned LOCK_COUNT    = 4,
  parameter int unsigned UNLOCK_ERRORS = 4,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             rx_clk,
  input  logic             reset,
  input  logic             rx_ready,
  input  logic [15:0]      rx_data,
  input  logic [1:0]       rxcharisk,
  input  logic             clear,
  output logic             locked,
  output logic             error,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] frame_count
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       good_q, good_d;
  logic [3:0]       bad_q, bad_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] frm_q, frm_d;

  logic [15:0] exp_data;
  logic [1:0]  exp_k;
  logic        match, comma, err_inc, frm_inc;

  always_comb begin
    exp_data = 16'hBCBC;
    exp_k    = 2'b11;
    case (idx_q)
      2'd1: begin exp_data = 16'h5854; exp_k = 2'b00; end
      2'd2: begin exp_data = 16'h4034; exp_k = 2'b00; end
      2'd3: begin exp_data = 16'h23A7; exp_k = 2'b00; end
      default: ;
    endcase
  end

  assign match = (rx_data == exp_data) && (rxcharisk == exp_k);
  assign comma = (rx_data == 16'hBCBC) && (rxcharisk == 2'b11);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    good_d  = good_q;
    bad_d   = bad_q;
    error_d = 1'b0;
    err_inc = 1'b0;
    frm_inc = 1'b0;
    if (!rx_ready) begin
      state_d = HUNT;
      idx_d   = '0;
      good_d  = '0;
      bad_d   = '0;
    end else begin
      case (state_q)
        HUNT: begin
          if (comma) begin
            state_d = SYNC;
            idx_d   = 2'd1;
            good_d  = '0;
          end
        end
        SYNC: begin
          if (!match) begin
            state_d = HUNT;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              good_d = good_q + 4'd1;
              if (good_q + 4'd1 == 4'(LOCK_COUNT)) begin
                state_d = LOCKED;
                bad_d   = '0;
              end
            end
          end
        end
        LOCKED: begin
          // No realignment while locked: the index free-runs through bad words.
          idx_d   = idx_q + 2'd1;
          frm_inc = (idx_q == 2'd3);
          if (!match) begin
            error_d = 1'b1;
            err_inc = 1'b1;
            bad_d   = bad_q + 4'd1;
            if (bad_q + 4'd1 == 4'(UNLOCK_ERRORS)) begin
              state_d = HUNT;
              idx_d   = '0;
            end
          end else begin
            bad_d = '0;
          end
        end
        default: begin
          state_d = HUNT;
          idx_d   = '0;
        end
      endcase
    end

    err_d = err_q;
    frm_d = frm_q;
    if (clear) begin
      err_d = '0;
      frm_d = '0;
    end else begin
      if (err_inc && !(&err_q)) err_d = err_q + CNT_W'(1);
      if (frm_inc && !(&frm_q)) frm_d = frm_q + CNT_W'(1);
    end
  end

  always_ff @(posedge rx_clk) begin
    if (reset) begin
      state_q <= HUNT;
      idx_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      error_q <= 1'b0;
      err_q   <= '0;
      frm_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      error_q <= error_d;
      err_q   <= err_d;
      frm_q   <= frm_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign error       = error_q;
  assign err_count   = err_q;
  assign frame_count = frm_q;

endmodule

// File: tb/tb_frame_check.sv
// Scoreboard bench for frame_check: a behavioural model pushes expected outputs
// per driven word; they are popped and checked one cycle later.
module tb_frame_check;

  localparam int LOCK = 4;
  localparam int UNL  = 4;

  logic        rx_clk = 1'b0;
  logic        reset, rx_ready, clear;
  logic [15:0] rx_data;
  logic [1:0]  rxcharisk;
  logic        locked_a, error_a, locked_b, error_b;
  logic [31:0] err_a, frm_a;
  logic [3:0]  err_b, frm_b;

  frame_check #(.LOCK_COUNT(LOCK), .UNLOCK_ERRORS(UNL), .CNT_W(32)) dut_a (
    .rx_clk(rx_clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
    .rxcharisk(rxcharisk), .clear(clear), .locked(locked_a), .error(error_a),
    .err_count(err_a), .frame_count(frm_a));

  frame_check #(.LOCK_COUNT(LOCK), .UNLOCK_ERRORS(UNL), .CNT_W(4)) dut_b (
    .rx_clk(rx_clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
    .rxcharisk(rxcharisk), .clear(clear), .locked(locked_b), .error(error_b),
    .err_count(err_b), .frame_count(frm_b));

  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic        l;
    logic        e;
    logic [31:0] ec;
    logic [31:0] fc;
    logic [3:0]  ec4;
    logic [3:0]  fc4;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // model state: 0 hunt, 1 sync, 2 locked
  int     m_st, m_idx, m_good, m_bad;
  longint m_ec, m_fc, m_ec4, m_fc4;
  bit     m_err;

  function automatic logic [17:0] word(input int i);
    case (i)
      0:       return {2'b11, 16'hBCBC};
      1:       return {2'b00, 16'h5854};
      2:       return {2'b00, 16'h4034};
      default: return {2'b00, 16'h23A7};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl(input logic [15:0] d, input logic [1:0] k,
                     input logic rdy, input logic clr, input logic rst);
    bit   hit, inc_e, inc_f;
    exp_t x;
    inc_e = 0; inc_f = 0; m_err = 0;
    if (rst) begin
      m_st = 0; m_idx = 0; m_good = 0; m_bad = 0;
      m_ec = 0; m_fc = 0; m_ec4 = 0; m_fc4 = 0;
    end else begin
      hit = ({k, d} == word(m_idx));
      if (!rdy) begin
        m_st = 0; m_idx = 0; m_good = 0; m_bad = 0;
      end else if (m_st == 0) begin
        if ({k, d} == word(0)) begin m_st = 1; m_idx = 1; m_good = 0; end
      end else if (m_st == 1) begin
        if (!hit) m_st = 0;
        else begin
          if (m_idx == 3) begin
            m_good++;
            if (m_good == LOCK) begin m_st = 2; m_bad = 0; end
          end
          m_idx = (m_idx + 1) % 4;
        end
      end else begin
        if (m_idx == 3) inc_f = 1;
        m_idx = (m_idx + 1) % 4;
        if (!hit) begin
          m_err = 1; inc_e = 1; m_bad++;
          if (m_bad == UNL) m_st = 0;
        end else m_bad = 0;
      end
      if (clr) begin
        m_ec = 0; m_fc = 0; m_ec4 = 0; m_fc4 = 0;
      end else begin
        if (inc_e && m_ec < 64'hFFFF_FFFF) m_ec++;
        if (inc_f && m_fc < 64'hFFFF_FFFF) m_fc++;
        if (inc_e && m_ec4 < 15) m_ec4++;
        if (inc_f && m_fc4 < 15) m_fc4++;
      end
    end
    x.l = (m_st == 2); x.e = m_err;
    x.ec = m_ec[31:0]; x.fc = m_fc[31:0];
    x.ec4 = m_ec4[3:0]; x.fc4 = m_fc4[3:0];
    q.push_back(x);
  endtask

  task automatic step(input logic [15:0] d, input logic [1:0] k,
                      input logic rdy = 1'b1, input logic clr = 1'b0, input logic rst = 1'b0);
    exp_t x;
    rx_data = d; rxcharisk = k; rx_ready = rdy; clear = clr; reset = rst;
    mdl(d, k, rdy, clr, rst);
    @(posedge rx_clk);
    #1;
    if (q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      x = q.pop_front();
      chk("locked",    {31'd0, locked_a}, {31'd0, x.l});
      chk("error",     {31'd0, error_a},  {31'd0, x.e});
      chk("err_count", err_a, x.ec);
      chk("frame_count", frm_a, x.fc);
      chk("locked_w4", {31'd0, locked_b}, {31'd0, x.l});
      chk("err_count_w4", {28'd0, err_b}, {28'd0, x.ec4});
      chk("frame_count_w4", {28'd0, frm_b}, {28'd0, x.fc4});
    end
  endtask

  task automatic send_word(input int i);
    logic [17:0] w;
    w = word(i);
    step(w[15:0], w[17:16]);
  endtask

  task automatic send_frames(input int n);
    for (int f = 0; f < n; f++)
      for (int i = 0; i < 4; i++) send_word(i);
  endtask

  initial begin
    rx_data = '0; rxcharisk = '0; rx_ready = 1'b1; clear = 1'b0; reset = 1'b1;
    step(16'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    step(16'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    chk("reset_locked", {31'd0, locked_a}, 32'd0);
    chk("reset_err", err_a, 32'd0);

    // clean stream: lock at the W3 completing frame 4
    send_frames(3);
    for (int i = 0; i < 3; i++) send_word(i);
    chk("pre_lock", {31'd0, locked_a}, 32'd0);
    send_word(3);
    chk("lock_after_16", {31'd0, locked_a}, 32'd1);
    send_frames(10);
    chk("frames_10", frm_a, 32'd10);
    chk("err_zero", err_a, 32'd0);

    // single corrupted W2
    send_word(0); send_word(1);
    step(16'h4035, 2'b00);
    chk("single_err_pulse", {31'd0, error_a}, 32'd1);
    send_word(3);
    chk("single_err_clears", {31'd0, error_a}, 32'd0);
    chk("single_err_cnt", err_a, 32'd1);
    chk("single_err_locked", {31'd0, locked_a}, 32'd1);

    // four garbage words drop lock
    for (int i = 0; i < 3; i++) step(16'h0000, 2'b00);
    chk("garbage_still_locked", {31'd0, locked_a}, 32'd1);
    step(16'h0000, 2'b00);
    chk("garbage_unlock", {31'd0, locked_a}, 32'd0);
    chk("garbage_err_cnt", err_a, 32'd5);
    send_frames(4);
    chk("relock", {31'd0, locked_a}, 32'd1);

    // clear, then drop rx_ready while locked
    step(16'h5854, 2'b00, 1'b1, 1'b1);
    chk("clear_err", err_a, 32'd0);
    step(16'h4034, 2'b00, 1'b0);
    chk("rdy_drop_unlock", {31'd0, locked_a}, 32'd0);
    chk("rdy_drop_frm_hold", frm_a, 32'd0);

    // SYNC: two good frames then a bad W1 returns to HUNT
    send_frames(2);
    send_word(0);
    step(16'h5855, 2'b00);
    chk("sync_bad_no_error", {31'd0, error_a}, 32'd0);
    chk("sync_bad_err_cnt", err_a, 32'd0);
    send_word(2); send_word(3);
    send_frames(4);
    chk("sync_relock", {31'd0, locked_a}, 32'd1);

    // non-comma BCBC (K=01) in HUNT must be ignored
    step(16'h0000, 2'b00, 1'b0);
    step(16'hBCBC, 2'b01);
    send_word(1); send_word(2); send_word(3);
    send_frames(3);
    chk("noncomma_ignored", {31'd0, locked_a}, 32'd0);
    send_frames(1);
    chk("noncomma_lock", {31'd0, locked_a}, 32'd1);

    // clear coinciding with an error: clear wins
    send_word(0);
    step(16'h1234, 2'b00, 1'b1, 1'b1);
    chk("clear_vs_error", err_a, 32'd0);
    send_word(2); send_word(3);

    // alternating good/bad words saturate the 4-bit counter
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) send_word(m_idx);
      else step(16'h0000, 2'b00);
    end
    chk("sat_err_w4", {28'd0, err_b}, 32'd15);
    chk("sat_err_w32", err_a, 32'd20);
    chk("sat_locked", {31'd0, locked_b}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
